// File: rtl/core_scan_pkg.sv
// core_scan_pkg: shared widths, flag position and FSM encoding for the INTEST scan port
package core_scan_pkg;
  localparam int X_W = 5;
  localparam int Y_W = 4;
  localparam int CNT_W = 8;
  localparam int FLAG_BIT = 0;
  localparam logic FLAG_SET = 1'b1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
endpackage

// File: rtl/core_scan_port_shift_reg.sv
// scan_shift_reg: LSB-first data register with parallel capture and parallel out
module scan_shift_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         shift,
  input  logic [W-1:0] cap_data,
  input  logic         tdi,
  output logic [W-1:0] dr
);
  always_ff @(posedge clk)
    if (rst) dr <= '0;
    else if (capture) dr <= cap_data;
    else if (shift) dr <= {tdi, dr[W-1:1]};
endmodule

// File: rtl/core_scan_port.sv
// core_scan_port: INTEST DR port that shifts an X word into core_logic, applies it for one clk and captures Y
module core_scan_port
  import core_scan_pkg::*;
#(
  parameter int X_W = core_scan_pkg::X_W,
  parameter int Y_W = core_scan_pkg::Y_W,
  parameter int CNT_W = core_scan_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tdi,
  output logic             tdo,
  output logic [X_W-1:0]   core_x,
  output logic             core_enable,
  input  logic [Y_W-1:0]   core_y,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);
  logic [1:0] state;
  logic [X_W-1:0] dr, apply_x;
  logic ovf, en_q, cap, sh, upd;
  assign cap = sel & capture_dr;
  assign sh = sel & shift_dr & ~capture_dr;
  assign upd = sel & update_dr & ~capture_dr & ~shift_dr;
  assign busy = state != IDLE;
  assign tdo = dr[0];
  assign core_enable = en_q & ~rst;
  // outside APPLY the core reloads its own Y, so its state cannot drift
  assign core_x = (state == APPLY && !rst) ? apply_x : {core_y, FLAG_SET};
  scan_shift_reg #(.W(X_W)) u_dr (
    .clk      (clk),
    .rst      (rst),
    .capture  (cap),
    .shift    (sh),
    .cap_data ({core_y, ovf}),
    .tdi      (tdi),
    .dr       (dr)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      apply_x <= '0;
      ovf <= 1'b0;
      step_cnt <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
      state <= state == APPLY ? CAPTURE : state == CAPTURE ? IDLE : upd ? APPLY : IDLE;
      if (upd && !busy) begin
        apply_x <= dr;
        step_cnt <= step_cnt + 1'b1;
      end
      ovf <= cap ? 1'b0 : (upd & busy) ? 1'b1 : ovf;
    end
endmodule
